// File: rtl/coeff_seq_if.sv
// Coefficient sequencer bus: run control and the table from the requester,
// coefficient words and status back from the sequencer.
interface coeff_seq_if #(
  parameter int NBITS = 8,
  parameter int N     = 128,
  parameter int LOG2N = 7,
  parameter int LANES = 4
);
  logic [NBITS*N-1:0]       coeff_table;
  logic                     start;
  logic                     auto_mode;
  logic [LOG2N-1:0]         stage_in;
  logic                     enable;
  logic [LANES*2*NBITS-1:0] coeff_out;
  logic                     valid;
  logic                     last;
  logic [LOG2N-1:0]         stage_out;
  logic                     busy;

  modport master (
    output coeff_table, start, auto_mode, stage_in, enable,
    input  coeff_out, valid, last, stage_out, busy
  );

  modport slave (
    input  coeff_table, start, auto_mode, stage_in, enable,
    output coeff_out, valid, last, stage_out, busy
  );
endinterface

// File: rtl/coeff_seq.sv
// Twiddle-coefficient sequencer for a parallel radix-2 DIF FFT.
// Streams W_N^k for LANES butterflies per enabled cycle, for one stage or
// for every remaining stage back-to-back; stalls cleanly on enable=0.
module coeff_seq #(
  parameter int NBITS = 8,
  parameter int N     = 128,
  parameter int LOG2N = 7,
  parameter int LANES = 4
) (
  input  logic       clk,
  input  logic       rst,
  coeff_seq_if.slave bus
);
  localparam int EW   = 2 * NBITS;
  localparam int HALF = N / 2;
  localparam int J    = N / (2 * LANES);
  localparam int WW   = LANES * EW;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [LOG2N-1:0] j_cnt;
  logic [LOG2N-1:0] stage;
  logic             auto_q;
  logic [WW-1:0]    coeff_p0;
  logic             vld_p0;
  logic             last_p0;
  logic [LOG2N-1:0] stage_p0;
  logic             busy_p0;

  logic [WW-1:0]    word_next;
  logic [LOG2N-1:0] stage_first;
  logic             j_last;
  logic             more_stages;

  // Exponent for lane p at word j of stage s: butterfly index shifted by the
  // stage and wrapped into the half-table, all at LOG2N bits.
  function automatic logic [LOG2N-1:0] exponent(input logic [LOG2N-1:0] j,
                                                input int p,
                                                input logic [LOG2N-1:0] s);
    logic [LOG2N-1:0] b;
    b = j * LOG2N'(LANES) + LOG2N'(p);
    return (b << s) & LOG2N'(HALF - 1);
  endfunction

  // Table entry k; entry 0 sits at the MSB end of the packed vector.
  function automatic logic [EW-1:0] table_entry(input logic [NBITS*N-1:0] tbl,
                                                input logic [LOG2N-1:0] k);
    return tbl[(HALF - 1 - int'(k)) * EW +: EW];
  endfunction

  // Out-of-range start stages collapse onto the final stage.
  assign stage_first = (bus.stage_in >= LOG2N'(LOG2N)) ? LOG2N'(LOG2N - 1)
                                                        : bus.stage_in;
  assign j_last      = (j_cnt == LOG2N'(J - 1));
  assign more_stages = auto_q && (stage != LOG2N'(LOG2N - 1));

  // Gather every lane's coefficient for the current (j, stage).
  always_comb begin
    word_next = '0;
    for (int p = 0; p < LANES; p++) begin
      word_next[p*EW +: EW] = table_entry(bus.coeff_table, exponent(j_cnt, p, stage));
    end
  end

  // Run-control FSM with the registered output stage (p0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      j_cnt    <= '0;
      stage    <= '0;
      auto_q   <= 1'b0;
      coeff_p0 <= '0;
      vld_p0   <= 1'b0;
      last_p0  <= 1'b0;
      stage_p0 <= '0;
      busy_p0  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          vld_p0  <= 1'b0;
          last_p0 <= 1'b0;
          if (bus.start) begin
            state   <= RUN;
            busy_p0 <= 1'b1;
            j_cnt   <= '0;
            stage   <= stage_first;
            auto_q  <= bus.auto_mode;
          end
        end
        RUN: begin
          if (bus.enable) begin
            coeff_p0 <= word_next;
            vld_p0   <= 1'b1;
            stage_p0 <= stage;
            last_p0  <= 1'b0;
            if (!j_last) begin
              j_cnt <= j_cnt + LOG2N'(1);
            end else if (more_stages) begin
              j_cnt <= '0;
              stage <= stage + LOG2N'(1);
            end else begin
              last_p0 <= 1'b1;
              busy_p0 <= 1'b0;
              j_cnt   <= '0;
              state   <= IDLE;
            end
          end else begin
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.coeff_out = coeff_p0;
  assign bus.valid     = vld_p0;
  assign bus.last      = last_p0;
  assign bus.stage_out = stage_p0;
  assign bus.busy      = busy_p0;
endmodule

// File: tb/tb_coeff_seq.sv
// Bench for coeff_seq at N=16, LANES=2, NBITS=4 with a word-sequence model.
module tb_coeff_seq;
  localparam int NB   = 4;
  localparam int NN   = 16;
  localparam int LG   = 4;
  localparam int LN   = 2;
  localparam int EW   = 2 * NB;
  localparam int HALF = NN / 2;
  localparam int J    = NN / (2 * LN);
  localparam int WW   = LN * EW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  coeff_seq_if #(.NBITS(NB), .N(NN), .LOG2N(LG), .LANES(LN)) bus ();

  coeff_seq #(.NBITS(NB), .N(NN), .LOG2N(LG), .LANES(LN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] tbl [HALF];
  logic [WW-1:0] held = '0;

  task automatic load_table(input bit ramp);
    logic [NB*NN-1:0] v;
    v = '0;
    for (int k = 0; k < HALF; k++) begin
      tbl[k] = ramp ? EW'(k) : EW'($urandom_range(0, 255));
      v[(HALF-1-k)*EW +: EW] = tbl[k];
    end
    bus.coeff_table = v;
  endtask

  // Word j of stage s: lane p carries W^((j*LANES+p)*2^s mod N/2).
  function automatic logic [WW-1:0] model_word(input int j, input int s);
    logic [WW-1:0] w;
    w = '0;
    for (int p = 0; p < LN; p++) w[p*EW +: EW] = tbl[((j*LN + p) << s) % HALF];
    return w;
  endfunction

  // Starts a run at the current negedge and follows it to its last word.
  task automatic run_check(input string name, input int s0, input bit au,
                           input int stall_pct, input bit restart);
    logic [WW-1:0] exp_w[$];
    int exp_s[$];
    int s_eff, s_end, total, idx, cycles;
    bit en_prev, is_last;
    s_eff = (s0 >= LG) ? LG - 1 : s0;
    s_end = au ? LG - 1 : s_eff;
    for (int s = s_eff; s <= s_end; s++)
      for (int j = 0; j < J; j++) begin
        exp_w.push_back(model_word(j, s));
        exp_s.push_back(s);
      end
    total = exp_w.size();
    bus.start = 1'b1; bus.auto_mode = au; bus.stage_in = LG'(s0);
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.valid !== 1'b0 || bus.coeff_out !== held) begin
      failures++;
      $display("FAIL %s start: busy=%b valid=%b coeff=%h required busy=1 valid=0 coeff=%h",
               name, bus.busy, bus.valid, bus.coeff_out, held);
    end
    en_prev = ($urandom_range(0, 99) >= stall_pct);
    bus.enable = en_prev;
    idx = 0; cycles = 0;
    while (idx < total && cycles < 400) begin
      @(negedge clk);
      cycles++;
      if (en_prev) begin
        is_last = (idx == total - 1);
        checks++;
        if (bus.valid !== 1'b1 || bus.coeff_out !== exp_w[idx]) begin
          failures++;
          $display("FAIL %s word%0d: valid=%b coeff=%h required valid=1 coeff=%h",
                   name, idx, bus.valid, bus.coeff_out, exp_w[idx]);
        end
        checks++;
        if (bus.stage_out !== LG'(exp_s[idx])) begin
          failures++;
          $display("FAIL %s stage%0d: stage_out=%0d required %0d", name, idx, bus.stage_out, exp_s[idx]);
        end
        checks++;
        if (bus.last !== is_last || bus.busy !== !is_last) begin
          failures++;
          $display("FAIL %s flags%0d: last=%b busy=%b required last=%b busy=%b",
                   name, idx, bus.last, bus.busy, is_last, !is_last);
        end
        held = exp_w[idx];
        idx++;
      end else begin
        checks++;
        if (bus.valid !== 1'b0 || bus.last !== 1'b0 || bus.busy !== 1'b1 || bus.coeff_out !== held) begin
          failures++;
          $display("FAIL %s stall: valid=%b last=%b busy=%b coeff=%h required 0 0 1 %h",
                   name, bus.valid, bus.last, bus.busy, bus.coeff_out, held);
        end
      end
      en_prev = ($urandom_range(0, 99) >= stall_pct);
      bus.enable = en_prev;
      bus.start = (restart && idx < total) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    bus.start = 1'b0;
    checks++;
    if (idx < total) begin
      failures++;
      $display("FAIL %s timeout: words=%0d required %0d", name, idx, total);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus.coeff_out !== '0 || bus.valid !== 1'b0 || bus.last !== 1'b0 ||
        bus.stage_out !== '0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: coeff=%h valid=%b last=%b stage=%0d busy=%b required all zero",
               bus.coeff_out, bus.valid, bus.last, bus.stage_out, bus.busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_stage();
    load_table(1'b1);
    run_check("single_s0", 0, 1'b0, 0, 1'b0);
    checks++;
    if (bus.coeff_out !== 16'h0706) begin
      failures++;
      $display("FAIL single_s0_final: coeff=%h required 0706", bus.coeff_out);
    end
    run_check("single_s1", 1, 1'b0, 0, 1'b0);
    checks++;
    if (bus.coeff_out !== 16'h0604) begin
      failures++;
      $display("FAIL single_s1_final: coeff=%h required 0604", bus.coeff_out);
    end
    run_check("single_s3", 3, 1'b0, 0, 1'b0);
    run_check("single_clamp", 9, 1'b0, 0, 1'b0);
  endtask

  task automatic test_auto();
    load_table(1'b1);
    run_check("auto_s2", 2, 1'b1, 0, 1'b0);
    checks++;
    if (bus.coeff_out !== 16'h0000 || bus.stage_out !== 4'd3) begin
      failures++;
      $display("FAIL auto_s2_final: coeff=%h stage=%0d required 0000 3", bus.coeff_out, bus.stage_out);
    end
    run_check("auto_s0", 0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_stall();
    load_table(1'b0);
    run_check("stall_single", 0, 1'b0, 50, 1'b0);
    run_check("stall_auto", 1, 1'b1, 40, 1'b0);
  endtask

  task automatic test_restart_ignored();
    load_table(1'b0);
    run_check("restart_single", 1, 1'b0, 20, 1'b1);
    run_check("restart_auto", 0, 1'b1, 20, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 8; r++) begin
      load_table(1'b0);
      run_check("b2b", $urandom_range(0, 6), 1'($urandom_range(0, 1)),
                $urandom_range(0, 30), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_midrun();
    load_table(1'b1);
    bus.start = 1'b1; bus.auto_mode = 1'b1; bus.stage_in = 4'd0; bus.enable = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.valid !== 1'b1 || bus.coeff_out !== 16'h0302) begin
      failures++;
      $display("FAIL midrun_word1: valid=%b coeff=%h required 1 0302", bus.valid, bus.coeff_out);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.coeff_out !== '0 || bus.valid !== 1'b0 || bus.last !== 1'b0 ||
        bus.stage_out !== '0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL midrun_async: coeff=%h valid=%b last=%b stage=%0d busy=%b required all zero",
               bus.coeff_out, bus.valid, bus.last, bus.stage_out, bus.busy);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.last !== 1'b0 || bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL midrun_hold: last=%b valid=%b busy=%b required 0 0 0", bus.last, bus.valid, bus.busy);
      end
    end
    rst = 1'b1;
    held = '0;
    @(negedge clk);
    run_check("post_reset", 0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    bus.start = 1'b0; bus.auto_mode = 1'b0; bus.stage_in = '0; bus.enable = 1'b0;
    load_table(1'b1);
    test_reset();
    test_single_stage();
    test_auto();
    test_stall();
    test_restart_ignored();
    test_back_to_back();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
